l2cache_wb: RTL and testbench
=============================

# l2cache_wb

Parametrised, inclusive, write-back, write-allocate set-associative L2 cache with byte-masked line-granular writes, dirty-victim writeback and back-invalidation of the L1s. It sits between the L1 request path (ufp) and the memory controller (dfp). Tags, data, valid, dirty and replacement state are held in internal flop arrays, so geometry is fully generic. One request is outstanding at a time.

## Interface
- WAYS, 4, associativity; power of two, 2..16
- SETS, 16, sets per way; power of two, at least 2
- LINE_BITS, 256, line width; power of two, at least 64
- ADDR_BITS, 32, physical address width
- Derived: LINE_BYTES=LINE_BITS/8, OFF_BITS=$clog2(LINE_BYTES), SET_BITS=$clog2(SETS), TAG_BITS=ADDR_BITS-SET_BITS-OFF_BITS
- clk  in  1  clock; one clock domain, rising edge
- rst  in  1  reset; asynchronous, active-high
- ufp_addr  in  ADDR_BITS  request address; offset bits ignored
- ufp_read  in  1  read request; held until ufp_resp
- ufp_write  in  1  write request; held until ufp_resp
- ufp_wmask  in  LINE_BYTES  byte enables for write
- ufp_wdata  in  LINE_BITS  write data
- ufp_rdata  out  LINE_BITS  read line; valid only while ufp_resp=1
- ufp_resp  out  1  one-cycle completion pulse
- invalidate  out  1  one-cycle back-invalidate pulse to the L1s
- invalidate_addr  out  ADDR_BITS  line address of the evicted victim, offset bits zero
- dfp_addr  out  ADDR_BITS  memory line address, offset bits zero
- dfp_read  out  1  memory read; held until dfp_resp
- dfp_write  out  1  memory write; held until dfp_resp
- dfp_wdata  out  LINE_BITS  victim line
- dfp_rdata  in  LINE_BITS  fill line; valid with dfp_resp
- dfp_resp  in  1  memory completion

## Operation
- States: IDLE, COMPARE, EVICT, WRITEBACK, FILL, INSTALL.
- IDLE: if ufp_read or ufp_write, register address, mask, data and op, then go to COMPARE. If both are high, the request is a write.
- COMPARE, hit: read drives ufp_rdata from the hit way. Write merges ufp_wdata bytes selected by wmask and sets dirty. Both assert ufp_resp, update PLRU toward the hit way, and go to IDLE.
- COMPARE, miss: choose the victim. The lowest-index invalid way wins; otherwise the PLRU victim. Latch the victim way. If the victim is valid, go to EVICT; otherwise go to FILL.
- EVICT: pulse invalidate with the victim tag and set. Go to WRITEBACK if the victim is dirty, else FILL.
- WRITEBACK: dfp_write=1, dfp_addr=victim address, dfp_wdata=victim line. On dfp_resp, go to FILL.
- FILL: dfp_read=1, dfp_addr=request line address. On dfp_resp, capture dfp_rdata and go to INSTALL.
- INSTALL: write the line, tag and valid=1 into the victim way with dirty=0. Go to COMPARE, which now hits; a write miss merges there.
- PLRU updates only on hits in COMPARE. Install does not touch PLRU; the following hit does.
- dfp_resp outside WRITEBACK or FILL is ignored.

## Timing
- Reset values: all outputs are 0, FSM is IDLE, all valid, dirty and PLRU bits are 0. Reset takes effect immediately (asynchronous).
- Data and tag arrays are not reset.
- Hit: request seen in IDLE at cycle N; ufp_resp at cycle N+1.
- Clean miss: ufp_resp at cycle N+3+D, where D is the number of cycles from dfp_read rising to dfp_resp, with D of at least 1.
- Dirty miss: adds EVICT (1 cycle) plus the writeback latency.
- dfp_addr, dfp_wdata, dfp_read and dfp_write are stable from assertion through the dfp_resp cycle. They deassert the cycle after dfp_resp.
- Reset mid-operation: any in-flight dfp transaction is abandoned and all lines are lost. Memory must tolerate a dropped request.
- ufp inputs must stay stable until ufp_resp. The request re-samples in IDLE only.

## Structure
- Shared package: l2_state_t enum and a function computing derived widths. It is parameter-generic and must not hard-code geometry.
- Sub-module tree_plru #(WAYS, SETS): per-set tree-PLRU bits (WAYS-1 per set) with asynchronous reset. Inputs are set index, hit one-hot and update strobe. Output is the victim one-hot for the presented set.
- Arrays are inferred flops in l2cache_wb. Read is combinational from the registered set index.

## Test plan
All scenarios use WAYS=4, SETS=16, LINE_BITS=256, ADDR_BITS=32. The set field is bits [8:5], so same-set addresses are spaced 0x200 apart.
- Read 0x1000 after reset: no invalidate, dfp_read with addr 0x1000, fill pattern A with D=3, ufp_resp at cycle N+6 with A. Re-read 0x1004: ufp_resp at N+1 with A, no dfp activity.
- Write 0x1000 with wmask=0x0000000F and wdata all 0xFF: hit. Read back returns A with bytes 0..3 equal to 0xFF; the dirty bit is set.
- Read 0x1200, 0x1400, 0x1600 (fills), then 0x1800: invalidate pulses with the PLRU victim address. If the victim is dirty, dfp_write with its line precedes dfp_read 0x1800.
- Hold dfp_resp low for 10 cycles during FILL: dfp_read and dfp_addr stay stable and ufp_resp stays 0. Completion then follows within 2 cycles.
- Assert rst during WRITEBACK: dfp_write and all outputs go to 0 without a clock edge. A subsequent read of 0x1000 misses.
- Hold ufp_read and ufp_write high together on 0x2000: treated as a write-allocate, and the line ends dirty.

Source files
------------

// File: rtl/l2cache_wb_pkg.sv
// Shared types and width helpers for the l2cache_wb write-back L2 cache.
// Everything here is parameter-generic; geometry comes from the instantiating module.
package l2cache_wb_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_COMPARE   = 3'd1,
      S_EVICT     = 3'd2,
      S_WRITEBACK = 3'd3,
      S_FILL      = 3'd4,
      S_INSTALL   = 3'd5
   } l2_state_t;

   function automatic int l2_tag_bits(input int addr_bits, input int sets, input int line_bits);
      return addr_bits - $clog2(sets) - $clog2(line_bits / 8);
   endfunction

endpackage

// File: rtl/l2cache_wb_plru.sv
// Per-set tree pseudo-LRU: WAYS-1 direction bits per set, heap-ordered (node 0 is root).
// A set bit means the victim lies in the right subtree; hits point the path away from the hit way.
module tree_plru #(
   parameter int WAYS = 4,
   parameter int SETS = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [$clog2(SETS)-1:0] set_i,
   input  logic [WAYS-1:0]         hit_i,
   input  logic                    update_i,
   output logic [WAYS-1:0]         victim_o
);
   localparam int LEVELS = $clog2(WAYS);

   logic [WAYS-2:0]   bits_q [SETS];
   logic [WAYS-2:0]   cur_bits;
   logic [WAYS-2:0]   bits_d;
   logic [LEVELS-1:0] hit_idx;
   logic [LEVELS-1:0] upd_node;
   logic [LEVELS-1:0] vic_node;
   logic [LEVELS-1:0] vic_idx;
   logic              vic_dir;

   always_comb begin
      // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
      hit_idx  = '0;
      upd_node = '0;
      vic_node = '0;
      vic_idx  = '0;
      vic_dir  = 1'b0;
      victim_o = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (hit_i[w]) hit_idx = LEVELS'(w);
      end
      cur_bits = bits_q[set_i];
      bits_d   = cur_bits;
      for (int l = 0; l < LEVELS; l++) begin
         upd_node         = LEVELS'((1 << l) - 1) + (hit_idx >> (LEVELS - l));
         bits_d[upd_node] = ~hit_idx[LEVELS-1-l];
      end
      for (int l = 0; l < LEVELS; l++) begin
         vic_dir  = cur_bits[vic_node];
         vic_idx  = (vic_idx << 1) | LEVELS'(vic_dir);
         vic_node = (vic_node << 1) + LEVELS'(1) + LEVELS'(vic_dir);
      end
      victim_o[vic_idx] = 1'b1;
   end

   // NOTE: sequential state is assigned with <= only, so every reader sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) bits_q[s] <= '0;
      end else if (update_i) begin
         bits_q[set_i] <= bits_d;
      end
   end

endmodule

// File: rtl/l2cache_wb.sv
// Inclusive write-back, write-allocate set-associative L2 with dirty-victim writeback
// and L1 back-invalidation. One request in flight; arrays are inferred flops.
module l2cache_wb
   import l2cache_wb_pkg::*;
#(
   parameter int WAYS      = 4,
   parameter int SETS      = 16,
   parameter int LINE_BITS = 256,
   parameter int ADDR_BITS = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_BITS-1:0]   ufp_addr,
   input  logic                   ufp_read,
   input  logic                   ufp_write,
   input  logic [LINE_BITS/8-1:0] ufp_wmask,
   input  logic [LINE_BITS-1:0]   ufp_wdata,
   output logic [LINE_BITS-1:0]   ufp_rdata,
   output logic                   ufp_resp,
   output logic                   invalidate,
   output logic [ADDR_BITS-1:0]   invalidate_addr,
   output logic [ADDR_BITS-1:0]   dfp_addr,
   output logic                   dfp_read,
   output logic                   dfp_write,
   output logic [LINE_BITS-1:0]   dfp_wdata,
   input  logic [LINE_BITS-1:0]   dfp_rdata,
   input  logic                   dfp_resp
);
   localparam int LINE_BYTES = LINE_BITS / 8;
   localparam int OFF_BITS   = $clog2(LINE_BYTES);
   localparam int SET_BITS   = $clog2(SETS);
   localparam int TAG_BITS   = l2_tag_bits(ADDR_BITS, SETS, LINE_BITS);
   localparam int WAY_BITS   = $clog2(WAYS);

   l2_state_t                     state_q, state_d;
   logic [ADDR_BITS-1:OFF_BITS]   req_addr_q;
   logic [LINE_BYTES-1:0]         req_wmask_q;
   logic [LINE_BITS-1:0]          req_wdata_q;
   logic                          req_write_q;
   logic [WAY_BITS-1:0]           victim_q, victim_d;
   logic [LINE_BITS-1:0]          fill_q;

   logic [TAG_BITS-1:0]           tag_q   [WAYS][SETS];
   logic [LINE_BITS-1:0]          data_q  [WAYS][SETS];
   logic [WAYS-1:0]               valid_q [SETS];
   logic [WAYS-1:0]               dirty_q [SETS];

   logic [SET_BITS-1:0]           set_idx;
   logic [TAG_BITS-1:0]           req_tag;
   logic [WAYS-1:0]               hit_vec;
   logic [WAY_BITS-1:0]           hit_way;
   logic                          hit;
   logic [LINE_BITS-1:0]          hit_line;
   logic [LINE_BITS-1:0]          merged_line;
   logic [WAYS-1:0]               plru_victim;
   logic [ADDR_BITS-1:0]          victim_addr;
   logic                          hit_upd;
   logic                          unused_offset;

   assign unused_offset = ^ufp_addr[OFF_BITS-1:0];
   assign set_idx       = req_addr_q[OFF_BITS +: SET_BITS];
   assign req_tag       = req_addr_q[ADDR_BITS-1 -: TAG_BITS];
   assign hit_upd       = (state_q == S_COMPARE) && hit;
   assign victim_addr   = {tag_q[victim_q][set_idx], set_idx, {OFF_BITS{1'b0}}};

   always_comb begin
      hit_vec = '0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[set_idx][w] && (tag_q[w][set_idx] == req_tag)) begin
            hit_vec[w] = 1'b1;
            hit_way    = WAY_BITS'(w);
         end
      end
      hit      = |hit_vec;
      hit_line = data_q[hit_way][set_idx];
      for (int b = 0; b < LINE_BYTES; b++) begin
         merged_line[b*8 +: 8] = req_wmask_q[b] ? req_wdata_q[b*8 +: 8] : hit_line[b*8 +: 8];
      end
   end

   tree_plru #(.WAYS(WAYS), .SETS(SETS)) u_plru (
      .clk      (clk),
      .rst      (rst),
      .set_i    (set_idx),
      .hit_i    (hit_vec),
      .update_i (hit_upd),
      .victim_o (plru_victim)
   );

   // An invalid way always beats the PLRU choice; the lowest-index one wins.
   always_comb begin
      victim_d = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (plru_victim[w]) victim_d = WAY_BITS'(w);
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[set_idx][w]) victim_d = WAY_BITS'(w);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:      if (ufp_read || ufp_write) state_d = S_COMPARE;
         S_COMPARE:   if (hit) state_d = S_IDLE;
                      else if (valid_q[set_idx][victim_d]) state_d = S_EVICT;
                      else state_d = S_FILL;
         S_EVICT:     state_d = dirty_q[set_idx][victim_q] ? S_WRITEBACK : S_FILL;
         S_WRITEBACK: if (dfp_resp) state_d = S_FILL;
         S_FILL:      if (dfp_resp) state_d = S_INSTALL;
         S_INSTALL:   state_d = S_COMPARE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         req_addr_q  <= '0;
         req_wmask_q <= '0;
         req_wdata_q <= '0;
         req_write_q <= 1'b0;
         victim_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && (ufp_read || ufp_write)) begin
            req_addr_q  <= ufp_addr[ADDR_BITS-1:OFF_BITS];
            req_wmask_q <= ufp_wmask;
            req_wdata_q <= ufp_wdata;
            req_write_q <= ufp_write;
         end
         if (state_q == S_COMPARE && !hit) victim_q <= victim_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
         end
      end else if (state_q == S_INSTALL) begin
         valid_q[set_idx][victim_q] <= 1'b1;
         dirty_q[set_idx][victim_q] <= 1'b0;
      end else if (hit_upd && req_write_q) begin
         dirty_q[set_idx][hit_way] <= 1'b1;
      end
   end

   // NOTE: tag/data storage and the fill buffer carry no reset; valid_q alone qualifies them.
   always_ff @(posedge clk) begin
      if (state_q == S_FILL && dfp_resp) fill_q <= dfp_rdata;
      if (state_q == S_INSTALL) begin
         tag_q[victim_q][set_idx]  <= req_tag;
         data_q[victim_q][set_idx] <= fill_q;
      end else if (hit_upd && req_write_q) begin
         data_q[hit_way][set_idx] <= merged_line;
      end
   end

   always_comb begin
      ufp_resp        = hit_upd;
      ufp_rdata       = (hit_upd && !req_write_q) ? hit_line : '0;
      invalidate      = (state_q == S_EVICT);
      invalidate_addr = invalidate ? victim_addr : '0;
      dfp_write       = (state_q == S_WRITEBACK);
      dfp_read        = (state_q == S_FILL);
      dfp_wdata       = dfp_write ? data_q[victim_q][set_idx] : '0;
      dfp_addr        = '0;
      if (dfp_write) dfp_addr = victim_addr;
      else if (dfp_read) dfp_addr = {req_tag, set_idx, {OFF_BITS{1'b0}}};
   end

endmodule

// File: tb/tb_l2cache_wb.sv
// Scoreboard bench for l2cache_wb: directed requests push expected responses, dfp
// traffic and invalidates into queues; independent monitors pop and compare.
module tb_l2cache_wb;

   typedef struct {
      logic [255:0] rdata;
      bit           chk_data;
      int           lat;
   } resp_t;

   typedef struct {
      bit           wr;
      logic [31:0]  addr;
      logic [255:0] wdata;
   } dfp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [31:0]   ufp_addr = '0;
   logic          ufp_read = 1'b0;
   logic          ufp_write = 1'b0;
   logic [31:0]   ufp_wmask = '0;
   logic [255:0]  ufp_wdata = '0;
   logic [255:0]  ufp_rdata;
   logic          ufp_resp;
   logic          invalidate;
   logic [31:0]   invalidate_addr;
   logic [31:0]   dfp_addr;
   logic          dfp_read;
   logic          dfp_write;
   logic [255:0]  dfp_wdata;
   logic [255:0]  dfp_rdata = '0;
   logic          dfp_resp = 1'b0;

   int            vectors = 0;
   int            miscompares = 0;
   int            cyc = 0;
   int            issue_cyc = 0;
   int            mem_delay = 1;

   resp_t         exp_resp[$];
   dfp_t          exp_dfp[$];
   logic [31:0]   exp_inv[$];
   logic [255:0]  mem [logic [31:0]];

   resp_t         mon_e;
   dfp_t          mem_e;
   logic [31:0]   inv_e;
   bit            mem_active = 1'b0;
   int            mem_cnt = 0;
   logic [31:0]   cur_addr;
   bit            cur_wr;
   logic [255:0]  cur_wdata;

   l2cache_wb #(.WAYS(4), .SETS(16), .LINE_BITS(256), .ADDR_BITS(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .ufp_addr        (ufp_addr),
      .ufp_read        (ufp_read),
      .ufp_write       (ufp_write),
      .ufp_wmask       (ufp_wmask),
      .ufp_wdata       (ufp_wdata),
      .ufp_rdata       (ufp_rdata),
      .ufp_resp        (ufp_resp),
      .invalidate      (invalidate),
      .invalidate_addr (invalidate_addr),
      .dfp_addr        (dfp_addr),
      .dfp_read        (dfp_read),
      .dfp_write       (dfp_write),
      .dfp_wdata       (dfp_wdata),
      .dfp_rdata       (dfp_rdata),
      .dfp_resp        (dfp_resp)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #100000;
      $display("FAIL global timeout");
      $fatal(1, "bench did not finish");
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] pat(input logic [31:0] a);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = a ^ (32'h9E37_79B9 * 32'(i + 1));
      return r;
   endfunction

   function automatic logic [255:0] mem_line(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return pat(a);
   endfunction

   // Memory: resp in the D-th cycle of a request; checks order, payload and stability.
   always @(negedge clk) begin
      if (rst) begin
         mem_active = 1'b0;
         dfp_resp   = 1'b0;
      end else if (dfp_read || dfp_write) begin
         if (!mem_active || dfp_resp) begin
            check("dfp request expected", 256'(exp_dfp.size() != 0), 256'(1));
            if (exp_dfp.size() != 0) begin
               mem_e = exp_dfp.pop_front();
               check("dfp op", 256'({dfp_read, dfp_write}), 256'({~mem_e.wr, mem_e.wr}));
               check("dfp addr", 256'(dfp_addr), 256'(mem_e.addr));
               if (mem_e.wr) check("dfp wdata", dfp_wdata, mem_e.wdata);
            end
            mem_active = 1'b1;
            mem_cnt    = 1;
            cur_addr   = dfp_addr;
            cur_wr     = dfp_write;
            cur_wdata  = dfp_wdata;
         end else begin
            mem_cnt++;
            check("dfp op stable", 256'({dfp_read, dfp_write}), 256'({~cur_wr, cur_wr}));
            check("dfp addr stable", 256'(dfp_addr), 256'(cur_addr));
            if (cur_wr) check("dfp wdata stable", dfp_wdata, cur_wdata);
         end
         dfp_resp = (mem_cnt >= mem_delay);
         if (dfp_resp) begin
            if (dfp_write) mem[dfp_addr] = dfp_wdata;
            else dfp_rdata = mem_line(dfp_addr);
         end
      end else begin
         mem_active = 1'b0;
         dfp_resp   = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (!rst && ufp_resp) begin
         check("ufp_resp expected", 256'(exp_resp.size() != 0), 256'(1));
         if (exp_resp.size() != 0) begin
            mon_e = exp_resp.pop_front();
            check("ufp_resp latency", 256'(cyc - issue_cyc), 256'(mon_e.lat));
            if (mon_e.chk_data) check("ufp_rdata", ufp_rdata, mon_e.rdata);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && invalidate) begin
         check("invalidate expected", 256'(exp_inv.size() != 0), 256'(1));
         if (exp_inv.size() != 0) begin
            inv_e = exp_inv.pop_front();
            check("invalidate_addr", 256'(invalidate_addr), 256'(inv_e));
         end
      end
   end

   task automatic exp_mem(input bit wr, input logic [31:0] addr, input logic [255:0] wdata);
      dfp_t e;
      e.wr = wr;
      e.addr = addr;
      e.wdata = wdata;
      exp_dfp.push_back(e);
   endtask

   task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] mask, input logic [255:0] wdata, input int d,
                         input bit chk, input logic [255:0] exp_data, input int lat);
      resp_t e;
      bit got;
      e.rdata = exp_data;
      e.chk_data = chk;
      e.lat = lat;
      exp_resp.push_back(e);
      mem_delay = d;
      got = 1'b0;
      @(negedge clk);
      ufp_addr  = addr;
      ufp_read  = rd;
      ufp_write = wr;
      ufp_wmask = mask;
      ufp_wdata = wdata;
      issue_cyc = cyc;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ufp_resp) begin
            got = 1'b1;
            break;
         end
      end
      check("ufp_resp within budget", 256'(got), 256'(1));
      ufp_read  = 1'b0;
      ufp_write = 1'b0;
      ufp_wmask = '0;
      ufp_wdata = '0;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " ufp_resp"}, 256'(ufp_resp), 256'(0));
      check({tag, " ufp_rdata"}, ufp_rdata, 256'(0));
      check({tag, " invalidate"}, 256'({invalidate, invalidate_addr}), 256'(0));
      check({tag, " dfp_rw"}, 256'({dfp_read, dfp_write}), 256'(0));
      check({tag, " dfp_addr"}, 256'(dfp_addr), 256'(0));
      check({tag, " dfp_wdata"}, dfp_wdata, 256'(0));
   endtask

   initial begin
      logic [255:0] line_a, line_a1, line_2000, line_m2, line_1600, line_m3;
      bit seen;
      line_a  = pat(32'h1000);
      line_a1 = line_a;
      line_a1[31:0] = 32'hFFFF_FFFF;
      line_2000 = pat(32'h2000);
      line_m2 = {32'h1234_5678, line_2000[223:0]};
      line_1600 = pat(32'h1600);
      line_m3 = line_1600;
      line_m3[63:32] = 32'hAAAA_AAAA;

      repeat (3) @(negedge clk);
      check_quiet("reset");
      rst = 1'b0;

      exp_mem(1'b0, 32'h1000, '0);
      do_req(1, 0, 32'h1000, '0, '0, 3, 1, line_a, 6);
      do_req(1, 0, 32'h1004, '0, '0, 3, 1, line_a, 1);
      do_req(0, 1, 32'h1000, 32'h0000_000F, {256{1'b1}}, 3, 0, '0, 1);
      do_req(1, 0, 32'h1000, '0, '0, 3, 1, line_a1, 1);

      exp_mem(1'b0, 32'h1200, '0);
      do_req(1, 0, 32'h1200, '0, '0, 2, 1, pat(32'h1200), 5);
      exp_mem(1'b0, 32'h1400, '0);
      do_req(1, 0, 32'h1400, '0, '0, 1, 1, pat(32'h1400), 4);
      exp_mem(1'b0, 32'h1600, '0);
      do_req(1, 0, 32'h1600, '0, '0, 4, 1, line_1600, 7);

      // Set 0 full; PLRU points at way 0 (0x1000, dirty).
      exp_inv.push_back(32'h1000);
      exp_mem(1'b1, 32'h1000, line_a1);
      exp_mem(1'b0, 32'h1800, '0);
      do_req(1, 0, 32'h1800, '0, '0, 2, 1, pat(32'h1800), 8);

      // Clean victim way 2; fill held off for 10 cycles.
      exp_inv.push_back(32'h1400);
      exp_mem(1'b0, 32'h3000, '0);
      do_req(1, 0, 32'h3000, '0, '0, 11, 1, pat(32'h3000), 15);

      // Read+write together is a write-allocate into way 1.
      exp_inv.push_back(32'h1200);
      exp_mem(1'b0, 32'h2000, '0);
      do_req(1, 1, 32'h2000, 32'hF000_0000, {8{32'h1234_5678}}, 2, 0, '0, 6);
      do_req(1, 0, 32'h2000, '0, '0, 2, 1, line_m2, 1);
      do_req(1, 0, 32'h1800, '0, '0, 2, 1, pat(32'h1800), 1);
      do_req(1, 0, 32'h3000, '0, '0, 2, 1, pat(32'h3000), 1);
      do_req(1, 0, 32'h1600, '0, '0, 2, 1, line_1600, 1);

      exp_inv.push_back(32'h2000);
      exp_mem(1'b1, 32'h2000, line_m2);
      exp_mem(1'b0, 32'h2200, '0);
      do_req(1, 0, 32'h2200, '0, '0, 1, 1, pat(32'h2200), 6);

      do_req(0, 1, 32'h1600, 32'h0000_00F0, {32{8'hAA}}, 1, 0, '0, 1);
      do_req(1, 0, 32'h1800, '0, '0, 1, 1, pat(32'h1800), 1);
      do_req(1, 0, 32'h3000, '0, '0, 1, 1, pat(32'h3000), 1);
      do_req(1, 0, 32'h2200, '0, '0, 1, 1, pat(32'h2200), 1);

      // Dirty 0x1600 is the victim; reset lands mid-writeback.
      exp_inv.push_back(32'h1600);
      exp_mem(1'b1, 32'h1600, line_m3);
      mem_delay = 20;
      seen = 1'b0;
      @(negedge clk);
      ufp_addr = 32'h1A00;
      ufp_read = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (dfp_write) begin
            seen = 1'b1;
            break;
         end
      end
      check("writeback started", 256'(seen), 256'(1));
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1 check_quiet("async reset");
      ufp_read = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      exp_mem(1'b0, 32'h1000, '0);
      do_req(1, 0, 32'h1000, '0, '0, 2, 1, line_a1, 5);

      repeat (3) @(negedge clk);
      check("resp queue drained", 256'(exp_resp.size()), 256'(0));
      check("dfp queue drained", 256'(exp_dfp.size()), 256'(0));
      check("invalidate queue drained", 256'(exp_inv.size()), 256'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
